rf_wb_scheduler: RTL and testbench

Write-back scheduler and scoreboard for the 8×16-bit register file of the 16-bit RISC core. It shares the register file's single write port between the ALU and load/memory write-back sources using round-robin arbitration. It also tracks pending destination registers so the issue stage stalls on RAW/WAW hazards. It sits between issue/execute/memory and the `reg_file` write port, which it drives as `I_en/I_we/I_selD/I_dataD`.

---
 rtl/rf_wb_scheduler.sv | 124 ++++++++++++
 tb/tb_rf_wb_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_scheduler.sv
// Write-back scheduler and scoreboard for the 8x16 register file: round-robin
// sharing of the single write port between ALU and load results, plus RAW/WAW issue stall.
module rf_wb_scheduler #(
    parameter int NREG = 8,
    parameter int DW   = 16,
    parameter int AW   = 3
) (
    input  logic            I_clk,
    input  logic            I_rst_n,
    input  logic            I_iss_valid,
    input  logic            I_iss_useA,
    input  logic            I_iss_useB,
    input  logic [AW-1:0]   I_iss_srcA,
    input  logic [AW-1:0]   I_iss_srcB,
    input  logic            I_iss_wr,
    input  logic [AW-1:0]   I_iss_dst,
    output logic            o_iss_ready,
    input  logic            I_alu_valid,
    input  logic [AW-1:0]   I_alu_dst,
    input  logic [DW-1:0]   I_alu_data,
    output logic            o_alu_ready,
    input  logic            I_mem_valid,
    input  logic [AW-1:0]   I_mem_dst,
    input  logic [DW-1:0]   I_mem_data,
    output logic            o_mem_ready,
    input  logic            I_flush,
    output logic            o_rf_en,
    output logic            o_rf_we,
    output logic [3:0]      o_rf_selD,
    output logic [DW-1:0]   o_rf_dataD,
    output logic [NREG-1:0] o_busy,
    output logic            o_err
);

    typedef enum logic {PRI_MEM, PRI_ALU} pri_t;

    pri_t            pri_q, pri_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            err_q;
    logic            grant_alu, grant_mem, wb_grant, iss_fire, err_hit;
    logic [AW-1:0]   wb_dst;
    logic [DW-1:0]   wb_data;

    // Arbiter: the granted source always hands priority to the other one.
    always_comb begin
        pri_d     = pri_q;
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (I_alu_valid && I_mem_valid) begin
            if (pri_q == PRI_MEM) begin
                grant_mem = 1'b1;
                pri_d     = PRI_ALU;
            end else begin
                grant_alu = 1'b1;
                pri_d     = PRI_MEM;
            end
        end else if (I_alu_valid) begin
            grant_alu = 1'b1;
            pri_d     = PRI_MEM;
        end else if (I_mem_valid) begin
            grant_mem = 1'b1;
            pri_d     = PRI_ALU;
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) pri_q <= PRI_MEM;
        else          pri_q <= pri_d;
    end

    assign wb_grant = grant_alu | grant_mem;
    assign wb_dst   = grant_alu ? I_alu_dst  : I_mem_dst;
    assign wb_data  = grant_alu ? I_alu_data : I_mem_data;

    // Stall decision uses only registered busy; a write-back granted this cycle
    // frees its register for issue in the next cycle.
    assign o_iss_ready = !I_flush
                       && !(I_iss_useA && busy_q[I_iss_srcA])
                       && !(I_iss_useB && busy_q[I_iss_srcB])
                       && !(I_iss_wr   && busy_q[I_iss_dst]);
    assign iss_fire    = I_iss_valid && o_iss_ready && I_iss_wr;
    assign err_hit     = wb_grant && !I_flush && !busy_q[wb_dst];

    // Set applied after clear so a same-edge issue to the written register stays busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_grant) busy_d[wb_dst] = 1'b0;
        if (I_flush)  busy_d = '0;
        if (iss_fire) busy_d[I_iss_dst] = 1'b1;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (err_hit) err_q <= 1'b1;
        end
    end

    // Output stage: one-cycle write strobe, address/data hold between writes.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            o_rf_en    <= 1'b0;
            o_rf_we    <= 1'b0;
            o_rf_selD  <= '0;
            o_rf_dataD <= '0;
        end else begin
            o_rf_en <= 1'b1;
            o_rf_we <= wb_grant;
            if (wb_grant) begin
                o_rf_selD  <= {{(4-AW){1'b0}}, wb_dst};
                o_rf_dataD <= wb_data;
            end
        end
    end

    assign o_alu_ready = grant_alu;
    assign o_mem_ready = grant_mem;
    assign o_busy      = busy_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Bench for rf_wb_scheduler: directed vector table, reset corner sequence, and
// randomized traffic against a scoreboard/round-robin reference model.
module tb_rf_wb_scheduler;

    logic        clk, rst_n;
    logic        iss_valid, iss_useA, iss_useB, iss_wr;
    logic [2:0]  iss_srcA, iss_srcB, iss_dst;
    logic        iss_ready;
    logic        alu_valid, alu_ready, mem_valid, mem_ready, flush;
    logic [2:0]  alu_dst, mem_dst;
    logic [15:0] alu_data, mem_data;
    logic        rf_en, rf_we, err;
    logic [3:0]  rf_selD;
    logic [15:0] rf_dataD;
    logic [7:0]  busy;

    rf_wb_scheduler #(.NREG(8), .DW(16), .AW(3)) dut (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_iss_valid(iss_valid), .I_iss_useA(iss_useA), .I_iss_useB(iss_useB),
        .I_iss_srcA(iss_srcA), .I_iss_srcB(iss_srcB), .I_iss_wr(iss_wr),
        .I_iss_dst(iss_dst), .o_iss_ready(iss_ready),
        .I_alu_valid(alu_valid), .I_alu_dst(alu_dst), .I_alu_data(alu_data),
        .o_alu_ready(alu_ready),
        .I_mem_valid(mem_valid), .I_mem_dst(mem_dst), .I_mem_data(mem_data),
        .o_mem_ready(mem_ready),
        .I_flush(flush), .o_rf_en(rf_en), .o_rf_we(rf_we), .o_rf_selD(rf_selD),
        .o_rf_dataD(rf_dataD), .o_busy(busy), .o_err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic iv, ua, ub, wr, av, mv, fl;
        logic [2:0] sa, sb, dst, ad, md;
        logic [15:0] adat, mdat;
    } in_t;

    typedef struct {
        in_t i;
        logic rdy, ar, mr, we, er;
        logic [7:0] bsy;
        logic [3:0] sel;
        logic [15:0] dat;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t vin(input logic iv, ua, input logic [2:0] sa, input logic wr,
                                input logic [2:0] dst, input logic av, input logic [2:0] ad,
                                input logic [15:0] adat, input logic mv, input logic [2:0] md,
                                input logic [15:0] mdat, input logic fl);
        in_t v;
        v.iv = iv; v.ua = ua; v.sa = sa; v.ub = 1'b0; v.sb = 3'd0; v.wr = wr; v.dst = dst;
        v.av = av; v.ad = ad; v.adat = adat; v.mv = mv; v.md = md; v.mdat = mdat; v.fl = fl;
        return v;
    endfunction

    task automatic addv(input in_t i, input logic rdy, ar, mr, input logic [7:0] bsy,
                        input logic we, input logic [3:0] sel, input logic [15:0] dat,
                        input logic er);
        vec_t v;
        v.i = i; v.rdy = rdy; v.ar = ar; v.mr = mr; v.bsy = bsy;
        v.we = we; v.sel = sel; v.dat = dat; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic drive(input in_t v);
        iss_valid = v.iv; iss_useA = v.ua; iss_srcA = v.sa; iss_useB = v.ub; iss_srcB = v.sb;
        iss_wr = v.wr; iss_dst = v.dst;
        alu_valid = v.av; alu_dst = v.ad; alu_data = v.adat;
        mem_valid = v.mv; mem_dst = v.md; mem_data = v.mdat; flush = v.fl;
    endtask

    // Reference model: per-register pending flags and a "whose turn" bit.
    logic [7:0]  m_busy;
    logic        m_alu_turn, m_we, m_en, m_err;
    logic [3:0]  m_sel;
    logic [15:0] m_data;

    task automatic model_reset();
        m_busy = 8'h00; m_alu_turn = 1'b0; m_we = 1'b0; m_en = 1'b0;
        m_err = 1'b0; m_sel = 4'd0; m_data = 16'h0;
    endtask

    task automatic model_comb(input in_t v, output logic rdy, output logic ga, output logic gm);
        rdy = !v.fl && !(v.ua && m_busy[v.sa]) && !(v.ub && m_busy[v.sb])
              && !(v.wr && m_busy[v.dst]);
        if (v.av && v.mv) begin
            ga = m_alu_turn; gm = !m_alu_turn;
        end else begin
            ga = v.av; gm = v.mv;
        end
    endtask

    task automatic model_step(input in_t v, input logic rdy, input logic ga, input logic gm);
        logic [2:0] d;
        d = ga ? v.ad : v.md;
        if ((ga || gm) && !v.fl && !m_busy[d]) m_err = 1'b1;
        if (ga || gm) m_busy[d] = 1'b0;
        if (v.fl) m_busy = 8'h00;
        if (v.iv && rdy && v.wr) m_busy[v.dst] = 1'b1;
        if (ga) m_alu_turn = 1'b0;
        if (gm) m_alu_turn = 1'b1;
        m_we = ga || gm;
        m_en = 1'b1;
        if (ga || gm) begin
            m_sel = {1'b0, d};
            m_data = ga ? v.adat : v.mdat;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(vin(0,0,0,0,0,0,0,16'h0,0,0,16'h0,0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(vin(0,0,0,0,0,0,0,16'h0,0,0,16'h0,0));
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", busy, 8'h00);
        check("reset_we", rf_we, 1'b0);
        check("reset_en", rf_en, 1'b0);
        check("reset_sel", rf_selD, 4'd0);
        check("reset_data", rf_dataD, 16'h0);
        check("reset_err", err, 1'b0);
        check("reset_ready", iss_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table: {inputs} -> comb ready/grants, then post-edge state.
        addv(vin(1,0,0,1,3, 0,0,16'h0,    0,0,16'h0,    0), 1,0,0, 8'h08, 0,4'd0,16'h0000, 0);
        addv(vin(1,1,3,0,0, 0,0,16'h0,    0,0,16'h0,    0), 0,0,0, 8'h08, 0,4'd0,16'h0000, 0);
        addv(vin(1,1,3,0,0, 1,3,16'hBEEF, 0,0,16'h0,    0), 0,1,0, 8'h00, 1,4'd3,16'hBEEF, 0);
        addv(vin(1,1,3,0,0, 0,0,16'h0,    0,0,16'h0,    0), 1,0,0, 8'h00, 0,4'd3,16'hBEEF, 0);
        addv(vin(1,0,0,1,1, 0,0,16'h0,    0,0,16'h0,    0), 1,0,0, 8'h02, 0,4'd3,16'hBEEF, 0);
        addv(vin(1,0,0,1,2, 0,0,16'h0,    0,0,16'h0,    0), 1,0,0, 8'h06, 0,4'd3,16'hBEEF, 0);
        addv(vin(0,0,0,0,0, 1,1,16'h1111, 1,2,16'h2222, 0), 1,0,1, 8'h02, 1,4'd2,16'h2222, 0);
        addv(vin(1,0,0,1,2, 1,1,16'h1111, 1,2,16'h2222, 0), 1,1,0, 8'h04, 1,4'd1,16'h1111, 0);
        addv(vin(1,0,0,1,1, 1,1,16'h1111, 1,2,16'h2222, 0), 1,0,1, 8'h02, 1,4'd2,16'h2222, 0);
        addv(vin(0,0,0,0,0, 1,1,16'h1111, 1,2,16'h2222, 0), 1,1,0, 8'h00, 1,4'd1,16'h1111, 0);
        addv(vin(1,0,0,1,4, 0,0,16'h0,    0,0,16'h0,    0), 1,0,0, 8'h10, 0,4'd1,16'h1111, 0);
        addv(vin(1,0,0,1,5, 0,0,16'h0,    0,0,16'h0,    0), 1,0,0, 8'h30, 0,4'd1,16'h1111, 0);
        addv(vin(1,0,0,1,5, 0,0,16'h0,    0,0,16'h0,    0), 0,0,0, 8'h30, 0,4'd1,16'h1111, 0);
        addv(vin(1,0,0,1,6, 0,0,16'h0,    0,0,16'h0,    0), 1,0,0, 8'h70, 0,4'd1,16'h1111, 0);
        addv(vin(1,0,0,1,7, 0,0,16'h0,    0,0,16'h0,    0), 1,0,0, 8'hF0, 0,4'd1,16'h1111, 0);
        addv(vin(1,0,0,1,0, 1,4,16'h4444, 0,0,16'h0,    1), 0,1,0, 8'h00, 1,4'd4,16'h4444, 0);
        addv(vin(0,0,0,0,0, 0,0,16'h0,    1,0,16'h0A0A, 1), 0,0,1, 8'h00, 1,4'd0,16'h0A0A, 0);
        addv(vin(0,0,0,0,0, 1,6,16'h6666, 0,0,16'h0,    0), 1,1,0, 8'h00, 1,4'd6,16'h6666, 1);
        addv(vin(0,0,0,0,0, 0,0,16'h0,    0,0,16'h0,    0), 1,0,0, 8'h00, 0,4'd6,16'h6666, 1);
        addv(vin(0,0,0,0,0, 0,0,16'h0,    0,0,16'h0,    0), 1,0,0, 8'h00, 0,4'd6,16'h6666, 1);

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            drive(vecs[k].i);
            #1;
            check($sformatf("v%0d_iss_ready", k), iss_ready, vecs[k].rdy);
            check($sformatf("v%0d_alu_ready", k), alu_ready, vecs[k].ar);
            check($sformatf("v%0d_mem_ready", k), mem_ready, vecs[k].mr);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_busy", k), busy, vecs[k].bsy);
            check($sformatf("v%0d_we", k), rf_we, vecs[k].we);
            check($sformatf("v%0d_en", k), rf_en, 1'b1);
            check($sformatf("v%0d_sel", k), rf_selD, vecs[k].sel);
            check($sformatf("v%0d_data", k), rf_dataD, vecs[k].dat);
            check($sformatf("v%0d_err", k), err, vecs[k].er);
        end

        // Asynchronous reset while a write strobe is active, after a MEM grant
        // left the turn with the ALU.
        @(negedge clk);
        drive(vin(1,0,0,1,3, 0,0,16'h0, 1,2,16'hABCD, 0));
        #1;
        check("rst_pre_mem_ready", mem_ready, 1'b1);
        @(posedge clk);
        #1;
        check("rst_pre_we", rf_we, 1'b1);
        check("rst_pre_busy", busy, 8'h08);
        drive(vin(0,0,0,0,0,0,0,16'h0,0,0,16'h0,0));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_we", rf_we, 1'b0);
        check("rst_async_busy", busy, 8'h00);
        check("rst_async_err", err, 1'b0);
        check("rst_async_en", rf_en, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(vin(0,0,0,0,0, 1,1,16'h5555, 1,2,16'h7777, 0));
        #1;
        check("rst_post_mem_ready", mem_ready, 1'b1);
        check("rst_post_alu_ready", alu_ready, 1'b0);
        @(posedge clk);
        #1;
        check("rst_post_sel", rf_selD, 4'd2);

        // Randomized traffic against the reference model, in four reset epochs.
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int c = 0; c < 100; c++) begin
                in_t v;
                logic rdy, ga, gm;
                v.iv = $urandom_range(0, 1); v.ua = $urandom_range(0, 1);
                v.ub = $urandom_range(0, 1); v.wr = $urandom_range(0, 1);
                v.sa = 3'($urandom_range(0, 7)); v.sb = 3'($urandom_range(0, 7));
                v.dst = 3'($urandom_range(0, 7));
                v.av = ($urandom_range(0, 2) != 0); v.mv = ($urandom_range(0, 2) != 0);
                v.ad = 3'($urandom_range(0, 7)); v.md = 3'($urandom_range(0, 7));
                v.adat = 16'($urandom); v.mdat = 16'($urandom);
                v.fl = ($urandom_range(0, 19) == 0);
                // Mostly target pending registers so error stays clear for a while.
                if (m_busy != 8'h00 && $urandom_range(0, 15) != 0) begin
                    for (int s = 0; s < 8; s++) begin
                        if (m_busy[(int'(v.ad) + s) % 8]) begin
                            v.ad = 3'((int'(v.ad) + s) % 8);
                            break;
                        end
                    end
                    for (int s = 0; s < 8; s++) begin
                        if (m_busy[(int'(v.md) + s) % 8]) begin
                            v.md = 3'((int'(v.md) + s) % 8);
                            break;
                        end
                    end
                end
                @(negedge clk);
                drive(v);
                #1;
                model_comb(v, rdy, ga, gm);
                check("rnd_iss_ready", iss_ready, rdy);
                check("rnd_alu_ready", alu_ready, ga);
                check("rnd_mem_ready", mem_ready, gm);
                model_step(v, rdy, ga, gm);
                @(posedge clk);
                #1;
                check("rnd_busy", busy, m_busy);
                check("rnd_we", rf_we, m_we);
                check("rnd_en", rf_en, m_en);
                check("rnd_sel", rf_selD, m_sel);
                check("rnd_data", rf_dataD, m_data);
                check("rnd_err", err, m_err);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
